// File: rtl/triangle_source.sv
// rtl/triangle_source.sv - emits a fixed table of triangles one vertex per cycle, paced by a busy handshake.
// Optional feature macro: TRI_LOOP_EN (wrap to the first triangle instead of stopping in DONE).
module triangle_source #(
  parameter int NUM_TRI = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       busy,
  output logic       nt,
  output logic [2:0] xo,
  output logic [2:0] yo
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    V0      = 3'd1,
    V1      = 3'd2,
    V2      = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5,
    DONE    = 3'd6
  } state_e;

  localparam logic [2:0] LAST_IDX = 3'(NUM_TRI - 1);

  state_e     state_q, state_d;
  logic [2:0] tri_idx_q, tri_idx_d;
  logic       nt_q, nt_d;
  logic [2:0] xo_q, xo_d;
  logic [2:0] yo_q, yo_d;

  // Returns {x, y} of vertex v of triangle t.
  function automatic logic [5:0] vertex(input logic [2:0] t, input logic [1:0] v);
    logic [5:0] xy;
    xy = 6'd0;
    case ({t, v})
      5'b000_00: xy = {3'd0, 3'd0};
      5'b000_01: xy = {3'd4, 3'd0};
      5'b000_10: xy = {3'd0, 3'd4};
      5'b001_00: xy = {3'd1, 3'd1};
      5'b001_01: xy = {3'd6, 3'd2};
      5'b001_10: xy = {3'd3, 3'd7};
      5'b010_00: xy = {3'd7, 3'd0};
      5'b010_01: xy = {3'd2, 3'd3};
      5'b010_10: xy = {3'd7, 3'd7};
      5'b011_00: xy = {3'd3, 3'd1};
      5'b011_01: xy = {3'd0, 3'd6};
      5'b011_10: xy = {3'd5, 3'd5};
      default:   xy = 6'd0;
    endcase
    return xy;
  endfunction

  always_comb begin
    state_d   = state_q;
    tri_idx_d = tri_idx_q;
    case (state_q)
      IDLE:    if (!busy) state_d = V0;
      V0:      state_d = V1;
      V1:      state_d = V2;
      V2:      state_d = WAIT_HI;
      WAIT_HI: if (busy) state_d = WAIT_LO;
      WAIT_LO: begin
        if (!busy) begin
          if (tri_idx_q == LAST_IDX) begin
`ifdef TRI_LOOP_EN
            tri_idx_d = 3'd0;
            state_d   = IDLE;
`else
            state_d   = DONE;
`endif
          end else begin
            tri_idx_d = tri_idx_q + 3'd1;
            state_d   = IDLE;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned with it.
  always_comb begin
    nt_d = 1'b0;
    xo_d = 3'd0;
    yo_d = 3'd0;
    case (state_d)
      V0: begin
        nt_d         = 1'b1;
        {xo_d, yo_d} = vertex(tri_idx_d, 2'd0);
      end
      V1:      {xo_d, yo_d} = vertex(tri_idx_d, 2'd1);
      V2:      {xo_d, yo_d} = vertex(tri_idx_d, 2'd2);
      default: begin
        nt_d = 1'b0;
        xo_d = 3'd0;
        yo_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tri_idx_q <= 3'd0;
      nt_q      <= 1'b0;
      xo_q      <= 3'd0;
      yo_q      <= 3'd0;
    end else begin
      state_q   <= state_d;
      tri_idx_q <= tri_idx_d;
      nt_q      <= nt_d;
      xo_q      <= xo_d;
      yo_q      <= yo_d;
    end
  end

  assign nt = nt_q;
  assign xo = xo_q;
  assign yo = yo_q;

endmodule

// File: tb/tb_triangle_source.sv
// tb/tb_triangle_source.sv - randomized directed bench for triangle_source against a table-driven model.
module tb_triangle_source;

  localparam int NT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy = 1'b0;
  logic       nt;
  logic [2:0] xo;
  logic [2:0] yo;

  int checks = 0;
  int errors = 0;

  // Reference: which triangle comes next and whether the table is exhausted.
  int exp_idx = 0;
  bit done = 1'b0;

  logic [2:0] tx [4][3] = '{'{3'd0, 3'd4, 3'd0}, '{3'd1, 3'd6, 3'd3},
                             '{3'd7, 3'd2, 3'd7}, '{3'd3, 3'd0, 3'd5}};
  logic [2:0] ty [4][3] = '{'{3'd0, 3'd0, 3'd4}, '{3'd1, 3'd2, 3'd7},
                             '{3'd0, 3'd3, 3'd7}, '{3'd1, 3'd6, 3'd5}};

  triangle_source #(.NUM_TRI(NT)) dut (
    .clk   (clk),
    .reset (reset),
    .busy  (busy),
    .nt    (nt),
    .xo    (xo),
    .yo    (yo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {nt, xo, yo};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed nt=%b x=%0d y=%0d, expected nt=%b x=%0d y=%0d",
             tag, obs[6], obs[5:3], obs[2:0], exp[6], exp[5:3], exp[2:0]);
    end
  endtask

  function automatic logic [6:0] vtx(input int t, input int v, input logic strobe);
    return {strobe, tx[t][v], ty[t][v]};
  endfunction

  // Caller leaves busy low with the block in IDLE; busy is noise during the vertices.
  task automatic send_tri(input int t);
    tick(); check("vertex0", vtx(t, 0, 1'b1));
    busy = 1'($urandom);
    tick(); check("vertex1", vtx(t, 1, 1'b0));
    busy = 1'($urandom);
    tick(); check("vertex2", vtx(t, 2, 1'b0));
    busy = 1'($urandom);
    tick(); check("after_v2", 7'd0);
    busy = 1'b0;
  endtask

  // w low cycles in WAIT_HI, h high cycles, fall, then k cycles of busy held in IDLE.
  task automatic handshake(input int w, input int h, input int k);
    busy = 1'b0;
    repeat (w) begin tick(); check("wait_hi", 7'd0); end
    busy = 1'b1;
    repeat (h) begin tick(); check("wait_lo", 7'd0); end
    busy = 1'b0;
    tick(); check("busy_fall", 7'd0);
    if (!done) begin
      if (exp_idx == NT - 1) begin
`ifdef TRI_LOOP_EN
        exp_idx = 0;
`else
        done = 1'b1;
`endif
      end else begin
        exp_idx++;
      end
    end
    busy = 1'b1;
    repeat (k) begin tick(); check("idle_stall", 7'd0); end
    busy = 1'b0;
  endtask

  task automatic do_reset(input logic b);
    reset = 1'b1;
    busy  = b;
    tick(); check("reset", 7'd0);
    reset = 1'b0;
    exp_idx = 0;
    done = 1'b0;
  endtask

  initial begin
    // Reset release then T0 two edges later.
    do_reset(1'b0);
    send_tri(0);

    // Long busy pulse after a few idle WAIT_HI cycles sends T1.
    handshake(3, 5, 0);
    send_tri(exp_idx);

    // Single-cycle pulse; reset lands while T2 is on vertex 1.
    handshake(0, 1, 0);
    tick(); check("t2_v0", vtx(exp_idx, 0, 1'b1));
    tick(); check("t2_v1", vtx(exp_idx, 1, 1'b0));
    reset = 1'b1;
    tick(); check("reset_mid_tri", 7'd0);
    reset = 1'b0;
    exp_idx = 0;
    send_tri(0);

    // Busy high straight out of reset holds IDLE.
    do_reset(1'b1);
    repeat (10) begin tick(); check("busy_hold_idle", 7'd0); end
    busy = 1'b0;
    send_tri(0);

    // Randomized handshakes across the end of the table.
    for (int r = 0; r < 7; r++) begin
      handshake(int'($urandom_range(0, 4)), int'($urandom_range(1, 6)),
                int'($urandom_range(0, 3)));
      if (done) begin
        repeat (8) begin
          busy = 1'($urandom);
          tick(); check("done_quiet", 7'd0);
        end
        busy = 1'b0;
      end else begin
        send_tri(exp_idx);
      end
    end

    do_reset(1'b0);
    send_tri(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
